// File: rtl/mdu_seq.sv
// mdu_seq: sequential RV32M multiply/divide unit.
// One-cycle 64-bit multiply; 32-iteration restoring divider with sign fix-up.
// Optional macro MDU_EARLY_OUT_EN: divide-by-zero, signed overflow and
// |b|>|a| divisions finish one edge after acceptance instead of 33.
module mdu_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] operand_a,
   input  logic [31:0] operand_b,
   input  logic        flush,
   output logic        busy,
   output logic        done,
   output logic [31:0] result
);

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 6;
   localparam int unsigned ITERS = 32;

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

   state_t            state_q, state_d;

   // captured operation and operands
   logic [1:0]        op_q, op_d;
   logic [XLEN-1:0]   a_q, a_d;
   logic [XLEN-1:0]   b_q, b_d;

   // divider working state
   logic [XLEN-1:0]   quo_q, quo_d;
   logic [XLEN-1:0]   rem_q, rem_d;
   logic [XLEN-1:0]   bmag_q, bmag_d;
   logic              qneg_q, qneg_d;
   logic              rneg_q, rneg_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   // registered outputs, next values
   logic              busy_d, done_d;
   logic [XLEN-1:0]   result_d;

   // datapath helpers
   logic              a_sx, b_sx;
   logic [63:0]       prod;
   logic [XLEN-1:0]   mul_res;
   logic [XLEN:0]     rem_sh;
   logic [XLEN+1:0]   diff;
   logic              div_signed, div_by_zero, div_ovf;
   logic [XLEN-1:0]   q_sel, r_sel, div_res;
   logic              early_hit;
   logic [XLEN-1:0]   early_res;
   logic              cap_signed;
   logic [XLEN-1:0]   cap_amag, cap_bmag;
   logic              iter_last;

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // next-state logic; flush aborts any operation in flight
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start && !flush) state_d = op[2] ? DIV : MUL;
         MUL:  state_d = flush ? IDLE : FIN;
         DIV: begin
            if (flush)                       state_d = IDLE;
            else if (iter_last || early_hit) state_d = FIN;
         end
         FIN:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // multiply product, divider step and sign fix-up
   always_comb begin
      a_sx    = (op_q != 2'b11) && a_q[XLEN-1];
      b_sx    = !op_q[1] && b_q[XLEN-1];
      prod    = {{32{a_sx}}, a_q} * {{32{b_sx}}, b_q};
      mul_res = (op_q == 2'b00) ? prod[31:0] : prod[63:32];

      rem_sh  = {rem_q, quo_q[XLEN-1]};
      diff    = {1'b0, rem_sh} - {2'b00, bmag_q};

      div_signed  = !op_q[0];
      div_by_zero = (b_q == '0);
      div_ovf     = div_signed && (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
      iter_last   = (cnt_q == CNT_W'(ITERS));

      q_sel = qneg_q ? -quo_q : quo_q;
      r_sel = rneg_q ? -rem_q : rem_q;
      if (div_by_zero) begin
         q_sel = 32'hFFFF_FFFF;
         r_sel = a_q;
      end else if (div_ovf) begin
         q_sel = 32'h8000_0000;
         r_sel = '0;
      end
      div_res = op_q[1] ? r_sel : q_sel;

`ifdef MDU_EARLY_OUT_EN
      // on the first DIV cycle quo_q still holds |a|
      early_hit = (cnt_q == '0) && (div_by_zero || div_ovf || (bmag_q > quo_q));
      if (div_by_zero)  early_res = op_q[1] ? a_q : 32'hFFFF_FFFF;
      else if (div_ovf) early_res = op_q[1] ? 32'h0 : 32'h8000_0000;
      else              early_res = op_q[1] ? a_q : 32'h0;
`else
      early_hit = 1'b0;
      early_res = '0;
`endif

      cap_signed = !op[0];
      cap_amag   = (cap_signed && operand_a[XLEN-1]) ? -operand_a : operand_a;
      cap_bmag   = (cap_signed && operand_b[XLEN-1]) ? -operand_b : operand_b;
   end

   // next values of registered outputs and working registers
   always_comb begin
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      quo_d    = quo_q;
      rem_d    = rem_q;
      bmag_d   = bmag_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      cnt_d    = cnt_q;
      result_d = result;
      case (state_q)
         IDLE: begin
            if (start && !flush) begin
               op_d   = op[1:0];
               a_d    = operand_a;
               b_d    = operand_b;
               quo_d  = cap_amag;
               bmag_d = cap_bmag;
               rem_d  = '0;
               cnt_d  = '0;
               qneg_d = cap_signed && (operand_a[XLEN-1] ^ operand_b[XLEN-1]);
               rneg_d = cap_signed && operand_a[XLEN-1];
            end
         end
         MUL: if (!flush) result_d = mul_res;
         DIV: begin
            if (!flush) begin
               if (iter_last) begin
                  result_d = div_res;
               end else if (early_hit) begin
                  result_d = early_res;
               end else begin
                  rem_d = diff[XLEN+1] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
                  quo_d = {quo_q[XLEN-2:0], !diff[XLEN+1]};
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: ;
      endcase
      busy_d = (state_d != IDLE);
      done_d = (state_d == FIN);
   end

   // output and counter registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
         cnt_q  <= '0;
      end else begin
         busy   <= busy_d;
         done   <= done_d;
         result <= result_d;
         cnt_q  <= cnt_d;
      end
   end

   // captured operands and divider state; no reset needed
   always_ff @(posedge clk) begin
      op_q   <= op_d;
      a_q    <= a_d;
      b_q    <= b_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      bmag_q <= bmag_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
   end

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed vector table plus flush/reset/held-start sequences.
module tb_mdu_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [2:0]  op;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic        flush;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int passed = 0;
   int total  = 0;

`ifdef MDU_EARLY_OUT_EN
   localparam int EARLY_LAT = 1;
`else
   localparam int EARLY_LAT = 33;
`endif

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      bit          early;
   } vec_t;

   mdu_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .op        (op),
      .operand_a (operand_a),
      .operand_b (operand_b),
      .flush     (flush),
      .busy      (busy),
      .done      (done),
      .result    (result)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // issue one op, return edges from acceptance to done (-1 on timeout)
   task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, output int lat, output logic [31:0] res);
      @(negedge clk);
      start = 1'b1; op = o; operand_a = a; operand_b = b;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check({name, "_busy"}, {31'b0, busy}, 32'd1);
      lat = -1;
      res = 'x;
      for (int k = 1; k <= 60; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (done) begin
            lat = k;
            res = result;
            break;
         end
      end
   endtask

   vec_t        vecs[$];
   int          lat;
   int          exp_lat;
   int          dones;
   logic [31:0] res;
   logic [31:0] prev;
   string       nm;

   initial begin
      rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; operand_a = '0; operand_b = '0;

      vecs.push_back('{3'b000, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 1'b0});
      vecs.push_back('{3'b011, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1'b0});
      vecs.push_back('{3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0});
      vecs.push_back('{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0});
      vecs.push_back('{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0});
      vecs.push_back('{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0});
      vecs.push_back('{3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 1'b0});
      vecs.push_back('{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0});
      vecs.push_back('{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0});
      vecs.push_back('{3'b101, 32'd100,       32'd7,         32'd14,        1'b0});
      vecs.push_back('{3'b111, 32'd100,       32'd7,         32'd2,         1'b0});
      vecs.push_back('{3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0});
      vecs.push_back('{3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1,         1'b0});
      vecs.push_back('{3'b101, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 1'b0});
      vecs.push_back('{3'b100, 32'hFFFF_FFF9, 32'd7,         32'hFFFF_FFFF, 1'b0});
      vecs.push_back('{3'b101, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 1'b1});
      vecs.push_back('{3'b111, 32'h1234_5678, 32'd0,         32'h1234_5678, 1'b1});
      vecs.push_back('{3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1});
      vecs.push_back('{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1});
      vecs.push_back('{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1});
      vecs.push_back('{3'b101, 32'd3,         32'd10,        32'd0,         1'b1});
      vecs.push_back('{3'b111, 32'd3,         32'd10,        32'd3,         1'b1});
      vecs.push_back('{3'b110, 32'hFFFF_FFFD, 32'd10,        32'hFFFF_FFFD, 1'b1});
      vecs.push_back('{3'b100, 32'hFFFF_FFFD, 32'd10,        32'd0,         1'b1});
      vecs.push_back('{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b1});

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy",   {31'b0, busy}, 32'd0);
      check("rst_done",   {31'b0, done}, 32'd0);
      check("rst_result", result,        32'd0);
      rst_n = 1'b1;

      // vector table
      foreach (vecs[i]) begin
         nm = $sformatf("v%0d_op%0d", i, vecs[i].op);
         exp_lat = vecs[i].op[2] ? (vecs[i].early ? EARLY_LAT : 33) : 1;
         run_op(nm, vecs[i].op, vecs[i].a, vecs[i].b, lat, res);
         check({nm, "_lat"}, 32'(lat), 32'(exp_lat));
         check({nm, "_res"}, res, vecs[i].exp);
         @(negedge clk);
         check({nm, "_done_clr"}, {31'b0, done, busy}, 32'd0);
         check({nm, "_hold"}, result, vecs[i].exp);
      end
      prev = result;

      // flush in DIV: flush seen at edge N+11, new MUL accepted at N+12
      dones = 0;
      @(negedge clk);
      start = 1'b1; op = 3'b101; operand_a = 32'd100; operand_b = 32'd7;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (done) dones++;
      end
      flush = 1'b1;
      @(posedge clk);
      @(negedge clk);
      flush = 1'b0;
      check("flush_busy",   {31'b0, busy},  32'd0);
      check("flush_done",   32'(dones + int'(done)), 32'd0);
      check("flush_result", result, prev);
      start = 1'b1; op = 3'b000; operand_a = 32'd3; operand_b = 32'd5;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check("post_flush_busy", {31'b0, busy, done}, 32'd2);
      @(posedge clk);
      @(negedge clk);
      check("post_flush_done", {31'b0, done}, 32'd1);
      check("post_flush_res",  result, 32'd15);

      // flush and start together in IDLE: start dropped
      @(negedge clk);
      start = 1'b1; flush = 1'b1; op = 3'b000; operand_a = 32'd9; operand_b = 32'd9;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      check("flush_start_busy", {31'b0, busy}, 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("flush_start_res", result, 32'd15);

      // start held through a whole DIV and its done cycle: accepted once
      @(negedge clk);
      start = 1'b1; op = 3'b101; operand_a = 32'd100; operand_b = 32'd7;
      @(posedge clk);
      @(negedge clk);
      operand_a = 32'd200;
      lat = -1;
      dones = 0;
      for (int k = 1; k <= 60; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (!busy) dones += 100;
         if (done) begin
            lat = k;
            break;
         end
      end
      check("held_lat", 32'(lat), 32'd33);
      check("held_res", result, 32'd14);
      check("held_busy_gap", 32'(dones), 32'd0);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check("held_after_fin", {31'b0, busy, done}, 32'd0);

      // reset at edge N+5 of a DIV with start held
      @(negedge clk);
      start = 1'b1; op = 3'b100; operand_a = 32'hFFFF_FFF9; operand_b = 32'd2;
      @(posedge clk);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         @(posedge clk);
      end
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("rst_mid_busy",   {31'b0, busy}, 32'd0);
      check("rst_mid_done",   {31'b0, done}, 32'd0);
      check("rst_mid_result", result,        32'd0);
      start = 1'b0;
      rst_n = 1'b1;
      dones = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (done || busy) dones++;
      end
      check("rst_mid_no_done", 32'(dones), 32'd0);

      // normal op after reset
      run_op("post_rst_mulhu", 3'b011, 32'h8000_0000, 32'h0000_0004, lat, res);
      check("post_rst_lat", 32'(lat), 32'd1);
      check("post_rst_res", res, 32'd2);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
